// File: rtl/serial_pkg.sv
// Shared definitions for the serial test path: receiver state encoding,
// board-level default rates and the oversample tick divisor calculation.
package serial_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 100_000_000;
  localparam int DEFAULT_BAUD_RATE       = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Rounded clocks-per-tick so the tick rate lands as close as possible to baud*os
  function automatic int tick_div(input int clk, input int baud, input int os);
    longint denom;
    denom = longint'(baud) * longint'(os);
    return int'((longint'(clk) + denom / 2) / denom);
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles;
// restart re-phases it so the first tick lands DIV cycles after the restart.
module serial_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk100,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk100) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with mid-bit oversampled sampling, ready/ack byte handoff,
// and sticky framing/overrun flags.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE      = 16
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int TICK_DIV = tick_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);

  logic            rx_meta;
  logic            rx_s;
  rx_state_t       state;
  logic [SW-1:0]   sample_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            restart;
  logic            tick;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign restart = (state == IDLE) && !rx_s;

  serial_baud_tick #(
    .DIV(TICK_DIV)
  ) u_baud_tick (
    .clk100 (clk100),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Frame FSM plus handshake; an ack and a new delivery in the same cycle leave rx_ready set
  always_ff @(posedge clk100) begin
    if (reset) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (rx_ready && rx_ack) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            sample_cnt <= '0;
            state      <= START;
          end
        end

        START: begin
          if (tick) begin
            if (sample_cnt == MID_LAST) begin
              sample_cnt <= '0;
              if (!rx_s) begin
                bit_idx <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (sample_cnt == BIT_LAST) begin
              sample_cnt <= '0;
              shift_reg  <= {rx_s, shift_reg[7:1]};
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (sample_cnt == BIT_LAST) begin
              sample_cnt <= '0;
              if (rx_s) begin
                if (!rx_ready || rx_ack) begin
                  rx_data       <= shift_reg;
                  rx_ready      <= 1'b1;
                  framing_error <= 1'b0;
                end else begin
                  overrun <= 1'b1;
                end
                state <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state         <= BREAK;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        // Hold here until the line recovers so a stuck-low line is not read as 0x00 frames
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx at a scaled-up baud rate (32 clocks per bit),
// compared against a transaction-level model of the receiver's delivery rules.
module tb_serial_rx;

  localparam int CLK_HALF  = 50;
  localparam int BIT_CLKS  = 32;
  localparam int BIT_TIME  = BIT_CLKS * 2 * CLK_HALF;
  localparam int SKEW_TIME = BIT_TIME / 50;
  localparam int TIMEOUT   = 4 * 11 * BIT_CLKS;
  localparam int LOOP_N    = 40;

  logic       clk100 = 1'b0;
  logic       reset  = 1'b1;
  logic       rx     = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic       m_ready;
  logic       m_fe;
  logic       m_ovr;
  logic [7:0] exp_q[$];

  logic [11:0] dut_vec;
  assign dut_vec = {rx_ready, framing_error, overrun, busy, rx_data};

  serial_rx #(
    .CLOCK_FREQUENCY(100_000_000),
    .BAUD_RATE      (3_125_000),
    .OVERSAMPLE     (16)
  ) dut (
    .clk100       (clk100),
    .reset        (reset),
    .rx           (rx),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #CLK_HALF clk100 = ~clk100;

  initial begin
    #(2 * CLK_HALF * 200_000);
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: what the receiver's visible state should be after each event
  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_ack();
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_now);
    logic was_ready;
    was_ready = m_ready;
    if (ack_now) model_ack();
    if (!stop_ok) begin
      m_fe = 1'b1;
    end else if (!was_ready || ack_now) begin
      m_data  = b;
      m_ready = 1'b1;
      m_fe    = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  function automatic logic [11:0] model_vec(input logic exp_busy);
    return {m_ready, m_fe, m_ovr, exp_busy, m_data};
  endfunction

  // Clock-aligned line driver: each call lasts exactly n cycles, changing rx 1 unit after an edge
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(stop_val, BIT_CLKS * stop_bits);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk100);
    #1;
    rx_ack = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL reset: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  task automatic test_single_frame();
    send_frame(8'h41, 1'b1, 1);
    model_frame(8'h41, 1'b1, 1'b0);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL frame_41: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    pulse_ack();
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL ack_41: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  task automatic test_glitch();
    drive_bit(1'b0, 5);
    rx = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy: busy got %b required 1", busy);
    end
    drive_bit(1'b1, BIT_CLKS);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL glitch_idle: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  task automatic test_framing();
    send_frame(8'h55, 1'b0, 1);
    drive_bit(1'b0, 3 * BIT_CLKS);
    model_frame(8'h55, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== model_vec(1'b1)) begin
      errors++;
      $display("[TB] FAIL framing_flag: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b1));
    end
    drive_bit(1'b1, BIT_CLKS);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL break_exit: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    send_frame(8'h0D, 1'b1, 1);
    model_frame(8'h0D, 1'b1, 1'b0);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL framing_clear: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h0A, 1'b1, 1);
    send_frame(8'h0D, 1'b1, 1);
    model_frame(8'h0A, 1'b1, 1'b0);
    model_frame(8'h0D, 1'b1, 1'b0);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL overrun: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    pulse_ack();
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL overrun_ack: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  // Stop sample of a clock-aligned frame lands 3 + 9.5*BIT_CLKS edges after rx falls
  task automatic test_ack_same_cycle();
    logic [7:0] b1;
    logic [7:0] b2;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    send_frame(b1, 1'b1, 1);
    fork
      send_frame(b2, 1'b1, 1);
      begin
        repeat (3 + (19 * BIT_CLKS) / 2 - 1) @(posedge clk100);
        #1;
        rx_ack = 1'b1;
        @(posedge clk100);
        #1;
        rx_ack = 1'b0;
      end
    join
    model_frame(b1, 1'b1, 1'b0);
    model_frame(b2, 1'b1, 1'b1);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL ack_same_cycle: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    pulse_ack();
  endtask

  // Free-running transmitter with skewed bit time against an acking consumer
  task automatic test_loopback(input int skew);
    int         bit_t;
    logic [7:0] last_b;
    bit_t  = BIT_TIME + skew;
    last_b = m_data;
    exp_q.delete();
    fork
      begin
        #7;
        for (int n = 0; n < LOOP_N; n++) begin
          logic [7:0] b;
          int         stops;
          b     = 8'($urandom_range(8'h20, 8'h7E));
          stops = $urandom_range(1, 2);
          exp_q.push_back(b);
          rx = 1'b0;
          #(bit_t);
          for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
          end
          rx = 1'b1;
          #(bit_t * stops);
        end
      end
      begin
        for (int n = 0; n < LOOP_N; n++) begin
          int waited;
          waited = 0;
          while (rx_ready !== 1'b1 && waited < TIMEOUT) begin
            @(posedge clk100);
            #1;
            waited++;
          end
          checks++;
          if (rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loopback_timeout: frame %0d rx_ready got %b required 1", n, rx_ready);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL loopback_extra: frame %0d got %h required no delivery", n, rx_data);
          end else begin
            last_b = exp_q.pop_front();
            if ({framing_error, overrun, rx_data} !== {2'b00, last_b}) begin
              errors++;
              $display("[TB] FAIL loopback_data: frame %0d {fe,ovr,data} got %b_%b_%h required 0_0_%h",
                       n, framing_error, overrun, rx_data, last_b);
            end
            rx_ack = 1'b1;
            @(posedge clk100);
            #1;
            rx_ack = 1'b0;
          end
        end
      end
    join
    m_data  = last_b;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ovr   = 1'b0;
    drive_bit(1'b1, BIT_CLKS);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL loopback_end: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CLKS);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_data_busy: busy got %b required 1", busy);
    end
    rx    = 1'b1;
    reset = 1'b1;
    @(posedge clk100);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL reset_mid_data: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
    drive_bit(1'b1, 2 * BIT_CLKS);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 1);
    model_frame(b, 1'b1, 1'b0);
    checks++;
    if (dut_vec !== model_vec(1'b0)) begin
      errors++;
      $display("[TB] FAIL after_reset: {rdy,fe,ovr,busy,data} got %h required %h", dut_vec, model_vec(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_ack_same_cycle();
    test_loopback(-SKEW_TIME);
    test_loopback(SKEW_TIME);
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver for the FPGA serial test path. It deserialises 8N1 asynchronous frames arriving on `rx` at `BAUD_RATE` and presents each received byte through a ready/acknowledge handshake. It flags framing and overrun errors. It is the counterpart of the serial transmitter on the same board and must accept that transmitter's output, including back-to-back frames with 1–2 stop-bit idle gaps, for loopback testing.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: clk100 frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bits/s.
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and ≥ 8.
- `clk100`, input, 1: system clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rx`, input, 1: asynchronous serial line, idle high.
- `rx_ack`, input, 1: consumer takes `rx_data`; sampled only while `rx_ready`=1.
- `rx_data`, output, 8: last good byte, LSB received first.
- `rx_ready`, output, 1: `rx_data` holds an unconsumed byte.
- `framing_error`, output, 1: sticky; the last frame had its stop bit low.
- `overrun`, output, 1: sticky; a frame completed while `rx_ready`=1.
- `busy`, output, 1: a frame is in progress (state ≠ IDLE).

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. All logic uses `rx_s` only. The synchroniser flops reset to 1.
- Tick divisor: `TICK_DIV` = round(`CLOCK_FREQUENCY`/(`BAUD_RATE`·`OVERSAMPLE`)), which is 651 for the defaults.
  - The tick counter is `$clog2(TICK_DIV)` bits wide. It emits a 1-cycle `tick` on wrap.
  - It is forced to restart on a start-edge detection, so ticks are phase-aligned to the frame.
- States:
  - **IDLE**: wait for `rx_s`=0. On detection, restart the tick counter, clear the sample counter, and go to START.
  - **START**: after `OVERSAMPLE/2` ticks (mid-bit), sample `rx_s`.
    - If 0: clear the bit index and go to DATA.
    - If 1: treat it as a glitch and return to IDLE; no flags change.
  - **DATA**: every `OVERSAMPLE` ticks, shift `rx_s` into the MSB of the shift register (right shift). After 8 samples, go to STOP.
  - **STOP**: after `OVERSAMPLE` ticks, sample `rx_s`.
    - If 1 (good frame), deliver the byte:
      - If `rx_ready`=0, or `rx_ack`=1 in this same cycle: load `rx_data`, set `rx_ready`=1, clear `framing_error`. Go to IDLE.
      - If `rx_ready`=1 and `rx_ack`=0: keep the old `rx_data` (the new byte is dropped) and set `overrun`. Go to IDLE.
    - If 0: set `framing_error`, do not deliver the byte, and go to BREAK.
  - **BREAK**: wait for `rx_s`=1, then go to IDLE. This keeps a held-low line from being read as a stream of 0x00 frames.
- Handshake:
  - `rx_ack`=1 while `rx_ready`=1 clears `rx_ready` on the next edge.
  - `overrun` also clears on that same acknowledge.
  - `rx_ack` while `rx_ready`=0 is ignored.
- `rx_data` only changes on a good-frame load. It is stable whenever `rx_ready`=1.
- Reset mid-frame: on the next edge the state returns to IDLE and the partial byte is discarded.
- Reset values: `rx_data`=0x00, `rx_ready`=0, `framing_error`=0, `overrun`=0, `busy`=0, state IDLE, tick and sample counters 0.

## Timing
- Edge detection lags the `rx` pin by 2 cycles (synchroniser) plus 1 cycle (state register).
- Sample points fall at (k+0.5) bit periods after start-edge detection, for k = 0 (start), 1..8 (data), 9 (stop), ±1 tick quantisation. One bit period is `TICK_DIV`·`OVERSAMPLE` = 10416 clocks at the defaults.
- `rx_ready` rises 1 cycle after the stop-bit sample tick. That is ≈ 9.5 bit periods + 3 cycles after the falling edge of `rx`.
- After a good stop sample the block is in IDLE, half a bit before the stop bit ends. It therefore accepts a new start edge with zero idle time.
- Tolerated baud mismatch: ±3 % with the default `OVERSAMPLE`.

## Structure
- `serial_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - a `tick_div(clk, baud, os)` constant function;
  - the default `CLOCK_FREQUENCY` and `BAUD_RATE`, shared with the transmitter.
- Sub-module `serial_baud_tick`: a parameterised divider with inputs `clk100`, `reset`, `restart` and output `tick`. It is reusable by a future oversampled transmitter.
- The synchroniser, FSM, shift register and handshake logic live in `serial_rx`.

## Test plan
- Reset, then send frame 0x41 at 9600 baud → `rx_ready` rises once with `rx_data`=0x41. `framing_error`=0 and `overrun`=0. Ack clears `rx_ready` the next cycle.
- `rx` low for 2 µs, then high → state returns to IDLE from START. No `rx_ready` and no flag change.
- Frame 0x55 with the stop bit driven low, line held low for 3 bit times, then frame 0x0D → `framing_error`=1 and no delivery from the first frame. The 0x0D frame delivers 0x0D and clears `framing_error`.
- Frames 0x0A then 0x0D back-to-back with no ack → `rx_data`=0x0A and `overrun`=1. Ack clears both `rx_ready` and `overrun`.
- Ack asserted in the exact cycle the second frame's stop is sampled → `rx_data`=second byte, `rx_ready` stays 1, `overrun`=0.
- Loopback from the transmitter at ±2 % clock skew, 200 frames of 0x20–0x7E → all bytes match. Assert `reset` mid-DATA → the partial frame is discarded and the next frame is received correctly.
